cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 97 +++++++++
 tb/tb_cpu_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/read/calc/write sequencer; imem fetch port, rf read/write ports, alu control/status, pc/busy/halted/err status
module cpu_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH = 8,
  parameter int OPCODE_WIDTH = 6,
  localparam int IW = OPCODE_WIDTH + 3 * BUS_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  output logic                    imem_req,
  output logic [BUS_WIDTH-1:0]    imem_addr,
  input  logic                    imem_ack,
  input  logic [IW-1:0]           imem_data,
  output logic [BUS_WIDTH-1:0]    rf_raddr1,
  output logic [BUS_WIDTH-1:0]    rf_raddr2,
  input  logic [DATA_WIDTH-1:0]   rf_rdata1,
  input  logic [DATA_WIDTH-1:0]   rf_rdata2,
  output logic                    rf_we,
  output logic [BUS_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]   rf_wdata,
  output logic                    alu_en,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  output logic [DATA_WIDTH-1:0]   alu_value1,
  output logic [DATA_WIDTH-1:0]   alu_value2,
  output logic [BUS_WIDTH-1:0]    alu_addr1,
  output logic [BUS_WIDTH-1:0]    alu_addr2,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_calc_done,
  input  logic                    alu_err,
  input  logic                    alu_finish,
  output logic [BUS_WIDTH-1:0]    pc,
  output logic                    busy,
  output logic                    halted,
  output logic                    err
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, SREAD, SCALC, SWRITE, HALT} state_t;
  state_t state;
  logic [IW-1:0] ir;
  logic [OPCODE_WIDTH-1:0] op;
  logic unused;
  assign op = ir[IW-1 -: OPCODE_WIDTH];
  assign rf_waddr = ir[3*BUS_WIDTH-1 -: BUS_WIDTH];
  assign rf_raddr1 = ir[2*BUS_WIDTH-1 -: BUS_WIDTH];
  assign rf_raddr2 = ir[BUS_WIDTH-1:0];
  assign alu_addr1 = rf_raddr1;
  assign alu_addr2 = rf_raddr2;
  assign rf_wdata = alu_result;
  assign imem_addr = pc;
  assign imem_req = state == FETCH;
  assign alu_en = state == SCALC;
  assign rf_we = state == SWRITE;
  assign halted = state == HALT;
  assign busy = !(state == IDLE || state == HALT);
  assign unused = alu_finish;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      alu_opcode <= '0;
      alu_value1 <= '0;
      alu_value2 <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: if (start) begin
          pc <= '0;
          err <= 1'b0;
          state <= FETCH;
        end
        FETCH: if (imem_ack) begin
          ir <= imem_data;
          alu_opcode <= imem_data[IW-1 -: OPCODE_WIDTH];
          state <= DECODE;
        end
        DECODE: begin
          state <= &op ? HALT : ~|op ? FETCH : SREAD;
          pc <= ~|op ? pc + 1'b1 : pc;
        end
        SREAD: begin
          alu_value1 <= rf_rdata1;
          alu_value2 <= rf_rdata2;
          state <= SCALC;
        end
        SCALC: if (alu_err) begin
          err <= 1'b1;
          state <= HALT;
        end else if (alu_calc_done) state <= SWRITE;
        SWRITE: begin
          pc <= pc + 1'b1;
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table-driven and directed checks of cpu_sequencer against an instruction memory, register file and ALU model
module tb_cpu_sequencer;
  localparam int IW = 30;
  localparam logic [5:0] HLT = 6'h3F;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic imem_req, imem_ack, rf_we, alu_en, alu_calc_done, alu_err, alu_finish, busy, halted, err;
  logic [7:0] imem_addr, rf_raddr1, rf_raddr2, rf_rdata1, rf_rdata2, rf_waddr, rf_wdata;
  logic [7:0] alu_value1, alu_value2, alu_addr1, alu_addr2, alu_result, pc;
  logic [5:0] alu_opcode;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] imem [256];
  logic [7:0] rf [256];
  logic ack_en = 1'b1, err_inj = 1'b0;
  int done_delay = 0, en_cnt = 0;
  int pass_cnt = 0, total = 0, en_cyc = 0, we_cyc = 0;
  typedef struct {logic [7:0] addr; logic [7:0] data;} wr_t;
  wr_t exp_q[$];
  typedef struct {logic [5:0] op; logic [7:0] r1; logic [7:0] r2; logic [7:0] res; bit wr;} vec_t;
  vec_t tv[7];

  cpu_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_value1(alu_value1), .alu_value2(alu_value2),
    .alu_addr1(alu_addr1), .alu_addr2(alu_addr2), .alu_result(alu_result),
    .alu_calc_done(alu_calc_done), .alu_err(alu_err), .alu_finish(alu_finish),
    .pc(pc), .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;
  assign imem_data = imem[imem_addr];
  assign imem_ack = imem_req & ack_en;
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  assign alu_calc_done = alu_en && en_cnt == done_delay;
  assign alu_err = alu_en & err_inj;
  assign alu_finish = 1'b0;

  function automatic logic [7:0] alu_f(input logic [5:0] o, input logic [7:0] a, input logic [7:0] b);
    return o == 6'd1 ? a + b : o == 6'd2 ? a - b : o == 6'd3 ? a & b : o == 6'd4 ? a | b : o == 6'd5 ? a ^ b : 8'h00;
  endfunction

  always_ff @(posedge clk) begin
    en_cnt <= alu_en ? en_cnt + 1 : 0;
    if (alu_en) alu_result <= alu_f(alu_opcode, alu_value1, alu_value2);
  end

  function automatic logic [IW-1:0] mk(input logic [5:0] o, input logic [7:0] d, input logic [7:0] a, input logic [7:0] b);
    return {o, d, a, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (alu_en) en_cyc++;
    if (rf_we) begin
      we_cyc++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        check("rf_waddr", 32'(rf_waddr), 32'(e.addr));
        check("rf_wdata", 32'(rf_wdata), 32'(e.data));
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int bound);
    int n = 0;
    while (!halted && n < bound) begin
      tick();
      n++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    int n, bad, e0, w0;
    for (int i = 0; i < 256; i++) begin
      imem[i] = {HLT, 24'h0};
      rf[i] = 8'h00;
    end
    tv[0] = '{6'd1, 8'h05, 8'h07, 8'h0C, 1'b1};
    tv[1] = '{6'd1, 8'hFF, 8'h01, 8'h00, 1'b1};
    tv[2] = '{6'd2, 8'h03, 8'h05, 8'hFE, 1'b1};
    tv[3] = '{6'd3, 8'hF0, 8'h3C, 8'h30, 1'b1};
    tv[4] = '{6'd4, 8'hA0, 8'h0C, 8'hAC, 1'b1};
    tv[5] = '{6'd5, 8'hAA, 8'hFF, 8'h55, 1'b1};
    tv[6] = '{6'd0, 8'h11, 8'h22, 8'h00, 1'b0};
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_imem_req", 32'(imem_req), 0);
    check("rst_alu_en", 32'(alu_en), 0);
    check("rst_rf_we", 32'(rf_we), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_err", 32'(err), 0);
    check("rst_alu_opcode", 32'(alu_opcode), 0);
    check("rst_alu_value1", 32'(alu_value1), 0);
    check("rst_alu_value2", 32'(alu_value2), 0);
    rstn = 1'b1;
    tick(); tick(); tick();
    check("idle_busy", 32'(busy), 0);
    check("idle_imem_req", 32'(imem_req), 0);

    // add r3 = r1 + r2, ack in the same cycle as the request
    imem[0] = mk(6'd1, 8'd3, 8'd1, 8'd2);
    rf[1] = 8'h05;
    rf[2] = 8'h07;
    push(8'd3, 8'h0C);
    pulse_start();
    check("fetch_req", 32'(imem_req), 1);
    check("fetch_addr", 32'(imem_addr), 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!imem_req && n < 20);
    check("add_ack_to_fetch", 32'(n), 5);
    check("add_pc", 32'(pc), 1);
    wait_halt(20);
    check("add_opcode_held", 32'(alu_opcode), 32'h3F);
    check("add_value1", 32'(alu_value1), 32'h05);
    check("add_value2", 32'(alu_value2), 32'h07);

    // table-driven program: one instruction per vector, then HALT
    e0 = en_cyc;
    for (int i = 0; i < 7; i++) begin
      imem[i] = mk(tv[i].op, 8'(32 + i), 8'(2 * i), 8'(2 * i + 1));
      rf[2 * i] = tv[i].r1;
      rf[2 * i + 1] = tv[i].r2;
      if (tv[i].wr) push(8'(32 + i), tv[i].res);
    end
    imem[7] = {HLT, 24'h0};
    pulse_start();
    wait_halt(100);
    check("tbl_pc", 32'(pc), 7);
    check("tbl_busy", 32'(busy), 0);
    check("tbl_alu_en_cycles", 32'(en_cyc - e0), 6);
    check("tbl_pending", 32'(exp_q.size()), 0);

    // NOP returns to FETCH two cycles after ack
    rf[1] = 8'h05;
    rf[2] = 8'h07;
    imem[0] = mk(6'd0, 8'd9, 8'd1, 8'd2);
    imem[1] = {HLT, 24'h0};
    e0 = en_cyc;
    w0 = we_cyc;
    pulse_start();
    n = 0;
    do begin
      tick();
      n++;
    end while (!imem_req && n < 20);
    check("nop_ack_to_fetch", 32'(n), 2);
    check("nop_pc", 32'(pc), 1);
    wait_halt(20);
    check("nop_alu_en", 32'(en_cyc - e0), 0);
    check("nop_rf_we", 32'(we_cyc - w0), 0);
    check("halt_busy", 32'(busy), 0);
    check("halt_pc", 32'(pc), 1);

    // ack withheld for 10 cycles, accepted on the 11th
    imem[0] = mk(6'd1, 8'd4, 8'd1, 8'd2);
    push(8'd4, 8'h0C);
    ack_en = 1'b0;
    pulse_start();
    check("restart_pc", 32'(pc), 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!imem_req || pc != 8'd0 || alu_en) bad++;
      tick();
    end
    check("fetch_stall", 32'(bad), 0);
    ack_en = 1'b1;
    tick();
    check("late_ack_req", 32'(imem_req), 0);
    check("late_ack_busy", 32'(busy), 1);
    wait_halt(20);
    check("late_ack_pc", 32'(pc), 1);

    // ALU error halts with err set and no write; restart clears err
    imem[0] = mk(6'd1, 8'd5, 8'd1, 8'd2);
    err_inj = 1'b1;
    w0 = we_cyc;
    pulse_start();
    wait_halt(20);
    check("aluerr_err", 32'(err), 1);
    check("aluerr_pc", 32'(pc), 0);
    check("aluerr_rf_we", 32'(we_cyc - w0), 0);
    err_inj = 1'b0;
    push(8'd5, 8'h0C);
    pulse_start();
    check("restart_err", 32'(err), 0);
    wait_halt(20);

    // three cycles without calc_done keep alu_en for four cycles
    imem[0] = mk(6'd2, 8'd6, 8'd2, 8'd1);
    push(8'd6, 8'h02);
    done_delay = 3;
    e0 = en_cyc;
    pulse_start();
    wait_halt(30);
    check("slow_alu_en_cycles", 32'(en_cyc - e0), 4);
    done_delay = 0;

    // pc wraps from FF to 00
    for (int i = 0; i < 255; i++) imem[i] = mk(6'd0, 8'd0, 8'd0, 8'd0);
    imem[255] = mk(6'd5, 8'd7, 8'd1, 8'd2);
    push(8'd7, 8'h02);
    w0 = we_cyc;
    pulse_start();
    n = 0;
    while (we_cyc == w0 && n < 2000) begin
      tick();
      n++;
    end
    check("wrap_write_seen", 32'(we_cyc - w0), 1);
    ack_en = 1'b0;
    tick();
    check("wrap_pc", 32'(pc), 0);
    check("wrap_fetch", 32'(imem_req), 1);

    // reset asserted during SCALC aborts without a write
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    imem[0] = mk(6'd1, 8'd8, 8'd1, 8'd2);
    ack_en = 1'b1;
    done_delay = 5;
    w0 = we_cyc;
    pulse_start();
    n = 0;
    while (!alu_en && n < 20) begin
      tick();
      n++;
    end
    check("reached_scalc", 32'(alu_en), 1);
    rstn = 1'b0;
    #1;
    check("abort_alu_en", 32'(alu_en), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_pc", 32'(pc), 0);
    check("abort_rf_we", 32'(rf_we), 0);
    tick();
    tick();
    rstn = 1'b1;
    tick(); tick(); tick();
    check("abort_no_write", 32'(we_cyc - w0), 0);
    check("abort_idle", 32'(busy | halted | imem_req), 0);
    done_delay = 0;
    check("final_pending", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
